// File: rtl/store_buffer_pkg.sv
// Shared types and helpers for the kernel store buffer: entry layout,
// default widths and the pointer-width function.
package store_buffer_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;

  typedef struct packed {
    logic [ADDR_WIDTH_DEF-1:0] addr;
    logic [DATA_WIDTH_DEF-1:0] data;
  } store_entry_t;

  function automatic int clog2_depth(input int depth);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < 32'(depth)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/store_fwd_match.sv
// Youngest-match search over the occupied FIFO entries, walking from the head
// (oldest) towards the tail so that later matches override earlier ones.
module store_fwd_match
  import store_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DEPTH      = 4,
  localparam int PTR_W     = clog2_depth(DEPTH)
) (
  input  logic [DEPTH-1:0][ADDR_WIDTH-1:0] addrs_i,
  input  logic [PTR_W-1:0]                 head_i,
  input  logic [PTR_W:0]                   count_i,
  input  logic [ADDR_WIDTH-1:0]            raddr_i,
  output logic                             hit_o,
  output logic [PTR_W-1:0]                 idx_o
);

  logic [PTR_W-1:0] pos_s;
  logic             match_s;

  // priority scan: oldest first, youngest valid match left standing
  always_comb begin
    hit_o   = 1'b0;
    idx_o   = {PTR_W{1'b0}};
    pos_s   = {PTR_W{1'b0}};
    match_s = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      pos_s   = head_i + PTR_W'(k);
      match_s = ((PTR_W+1)'(k) < count_i) && (addrs_i[pos_s] == raddr_i);
      hit_o   = hit_o | match_s;
      idx_o   = match_s ? pos_s : idx_o;
    end
  end

endmodule

// File: rtl/store_buffer.sv
// In-order store FIFO between an HLS kernel store port and a RAM write port,
// with load forwarding so buffered stores are never shadowed by stale RAM data.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DEPTH      = 4,
  localparam int PTR_W     = clog2_depth(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen_in,
  input  logic [ADDR_WIDTH-1:0] waddr_in,
  input  logic [DATA_WIDTH-1:0] wdata_in,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] raddr_in,
  output logic [DATA_WIDTH-1:0] rdata_out,
  input  logic                  drain_en,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [PTR_W:0]        count,
  output logic                  empty,
  output logic                  overflow
);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1'b1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1'b1);
  localparam logic [PTR_W:0]   CNT_MAX = (PTR_W+1)'(DEPTH);

  logic [DEPTH-1:0][ADDR_WIDTH-1:0] addr_q;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q;

  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [PTR_W:0]        count_q, count_d;
  logic                  empty_q, in_ready_q, overflow_q, overflow_d;
  logic                  hit_q;
  logic [DATA_WIDTH-1:0] fwd_data_q;

  logic                  full_s, push_s, pop_s;
  logic                  fwd_hit_s;
  logic [PTR_W-1:0]      fwd_idx_s;

  // full is registered state, so a pop on this edge never frees room for a push
  always_comb begin
    full_s     = (count_q == CNT_MAX);
    push_s     = wen_in & ~full_s;
    pop_s      = ~empty_q & drain_en;
    overflow_d = overflow_q | (wen_in & full_s);
    if (push_s) begin
      tail_d = tail_q + PTR_ONE;
    end else begin
      tail_d = tail_q;
    end
    if (pop_s) begin
      head_d = head_q + PTR_ONE;
    end else begin
      head_d = head_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  store_fwd_match #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_match (
    .addrs_i (addr_q),
    .head_i  (head_q),
    .count_i (count_q),
    .raddr_i (raddr_in),
    .hit_o   (fwd_hit_s),
    .idx_o   (fwd_idx_s)
  );

  // control state, status flags and the forwarding register
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= {PTR_W{1'b0}};
      tail_q     <= {PTR_W{1'b0}};
      count_q    <= {(PTR_W+1){1'b0}};
      empty_q    <= 1'b1;
      in_ready_q <= 1'b1;
      overflow_q <= 1'b0;
      hit_q      <= 1'b0;
      fwd_data_q <= {DATA_WIDTH{1'b0}};
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      empty_q    <= (count_d == {(PTR_W+1){1'b0}});
      in_ready_q <= (count_d != CNT_MAX);
      overflow_q <= overflow_d;
      hit_q      <= fwd_hit_s;
      fwd_data_q <= data_q[fwd_idx_s];
    end
  end

  // entry storage is deliberately left unreset
  always_ff @(posedge clk) begin
    if (push_s) begin
      addr_q[tail_q] <= waddr_in;
      data_q[tail_q] <= wdata_in;
    end
  end

  assign in_ready  = in_ready_q;
  assign count     = count_q;
  assign empty     = empty_q;
  assign overflow  = overflow_q;
  assign mem_wen   = pop_s;
  assign mem_waddr = addr_q[head_q];
  assign mem_wdata = data_q[head_q];
  assign mem_raddr = raddr_in;
  assign rdata_out = hit_q ? fwd_data_q : mem_rdata;

endmodule

// File: tb/tb_store_buffer.sv
// Scenario tasks plus a negedge scoreboard that models the FIFO, RAM writes,
// status flags and load forwarding independently of the design.
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        wen_in;
  logic [4:0]  waddr_in;
  logic [31:0] wdata_in;
  logic        in_ready;
  logic [4:0]  raddr_in;
  logic [31:0] rdata_out;
  logic        drain_en;
  logic        mem_wen;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic [4:0]  mem_raddr;
  logic [31:0] mem_rdata;
  logic [2:0]  count;
  logic        empty;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  store_entry_t exp_q[$];
  store_entry_t ent;
  int           sz;
  logic [2:0]   sz3;
  bit           mdl_ovf  = 1'b0;
  bit           ld_vld   = 1'b0;
  bit           exp_hit  = 1'b0;
  logic [31:0]  exp_fwd  = 32'd0;

  store_buffer #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .wen_in(wen_in), .waddr_in(waddr_in), .wdata_in(wdata_in), .in_ready(in_ready),
    .raddr_in(raddr_in), .rdata_out(rdata_out), .drain_en(drain_en),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .count(count), .empty(empty), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: checks this cycle's outputs, then applies the coming edge to the model
  always @(negedge clk) begin
    if (ld_vld) begin
      checks++;
      if (rdata_out !== (exp_hit ? exp_fwd : mem_rdata)) begin
        failures++;
        $display("FAIL sb_rdata got=%0d exp=%0d", rdata_out, exp_hit ? exp_fwd : mem_rdata);
      end
    end
    checks++;
    if (mem_raddr !== raddr_in) begin
      failures++;
      $display("FAIL sb_mem_raddr got=%0d exp=%0d", mem_raddr, raddr_in);
    end
    if (rst) begin
      exp_q.delete();
      mdl_ovf = 1'b0;
      exp_hit = 1'b0;
      ld_vld  = 1'b1;
    end else begin
      sz  = exp_q.size();
      sz3 = sz[2:0];
      checks++;
      if (count !== sz3 || empty !== (sz == 0) || in_ready !== (sz != DEPTH)) begin
        failures++;
        $display("FAIL sb_status got count=%0d empty=%0b in_ready=%0b exp count=%0d", count, empty, in_ready, sz);
      end
      checks++;
      if (overflow !== mdl_ovf) begin
        failures++;
        $display("FAIL sb_overflow got=%0b exp=%0b", overflow, mdl_ovf);
      end
      exp_hit = 1'b0;
      for (int j = 0; j < sz; j++) begin
        if (exp_q[j].addr == raddr_in) begin
          exp_hit = 1'b1;
          exp_fwd = exp_q[j].data;
        end
      end
      ld_vld = 1'b1;
      checks++;
      if (mem_wen !== (drain_en && sz != 0)) begin
        failures++;
        $display("FAIL sb_mem_wen got=%0b exp=%0b", mem_wen, (drain_en && sz != 0));
      end else if (mem_wen) begin
        ent = exp_q.pop_front();
        checks++;
        if (mem_waddr !== ent.addr || mem_wdata !== ent.data) begin
          failures++;
          $display("FAIL sb_drain got addr=%0d data=%0d exp addr=%0d data=%0d", mem_waddr, mem_wdata, ent.addr, ent.data);
        end
      end
      if (wen_in) begin
        if (sz == DEPTH) begin
          mdl_ovf = 1'b1;
        end else begin
          ent.addr = waddr_in;
          ent.data = wdata_in;
          exp_q.push_back(ent);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (count !== 3'd0 || empty !== 1'b1 || in_ready !== 1'b1 || mem_wen !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got count=%0d empty=%0b in_ready=%0b mem_wen=%0b ovf=%0b",
               count, empty, in_ready, mem_wen, overflow);
    end
  endtask

  task automatic test_single_store();
    wen_in = 1'b1; waddr_in = 5'd3; wdata_in = 32'd5; drain_en = 1'b0;
    tick();
    wen_in = 1'b0;
    tick();
    tick();
    checks++;
    if (count !== 3'd1 || mem_wen !== 1'b0) begin
      failures++;
      $display("FAIL single_held got count=%0d mem_wen=%0b exp count=1 mem_wen=0", count, mem_wen);
    end
    drain_en = 1'b1;
    #1;
    checks++;
    if (mem_wen !== 1'b1 || mem_waddr !== 5'd3 || mem_wdata !== 32'd5) begin
      failures++;
      $display("FAIL single_drain got wen=%0b addr=%0d data=%0d exp 1/3/5", mem_wen, mem_waddr, mem_wdata);
    end
    tick();
    checks++;
    if (mem_wen !== 1'b0 || empty !== 1'b1) begin
      failures++;
      $display("FAIL single_after got wen=%0b empty=%0b exp 0/1", mem_wen, empty);
    end
    drain_en = 1'b0;
  endtask

  task automatic test_fill_overflow();
    drain_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wen_in = 1'b1; waddr_in = 5'(i); wdata_in = 32'(10 + i);
      tick();
      if (i == 3) begin
        checks++;
        if (in_ready !== 1'b0 || overflow !== 1'b0) begin
          failures++;
          $display("FAIL fill_full got in_ready=%0b ovf=%0b exp 0/0", in_ready, overflow);
        end
      end
    end
    wen_in = 1'b0;
    checks++;
    if (overflow !== 1'b1 || count !== 3'd4) begin
      failures++;
      $display("FAIL fill_overflow got ovf=%0b count=%0d exp 1/4", overflow, count);
    end
    drain_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (mem_wen !== 1'b1 || mem_wdata !== 32'(10 + k) || mem_waddr !== 5'(k)) begin
        failures++;
        $display("FAIL fill_order got wen=%0b addr=%0d data=%0d exp addr=%0d data=%0d",
                 mem_wen, mem_waddr, mem_wdata, k, 10 + k);
      end
      tick();
    end
    #1;
    checks++;
    if (mem_wen !== 1'b0 || empty !== 1'b1) begin
      failures++;
      $display("FAIL fill_dropped got wen=%0b data=%0d empty=%0b exp wen=0 empty=1", mem_wen, mem_wdata, empty);
    end
    drain_en = 1'b0;
  endtask

  task automatic test_forward();
    drain_en = 1'b0; mem_rdata = 32'd99;
    wen_in = 1'b1; waddr_in = 5'd7; wdata_in = 32'd1;
    tick();
    wdata_in = 32'd2;
    tick();
    wen_in = 1'b0; raddr_in = 5'd7;
    tick();
    checks++;
    if (rdata_out !== 32'd2) begin
      failures++;
      $display("FAIL fwd_youngest got=%0d exp=2", rdata_out);
    end
    raddr_in = 5'd8;
    tick();
    checks++;
    if (rdata_out !== 32'd99) begin
      failures++;
      $display("FAIL fwd_miss got=%0d exp=99", rdata_out);
    end
    drain_en = 1'b1;
    tick();
    tick();
    drain_en = 1'b0;
    wen_in = 1'b1; waddr_in = 5'd9; wdata_in = 32'd44;
    tick();
    wen_in = 1'b0; drain_en = 1'b1; raddr_in = 5'd9;
    tick();
    checks++;
    if (rdata_out !== 32'd44 || empty !== 1'b1) begin
      failures++;
      $display("FAIL fwd_popped got=%0d empty=%0b exp 44/1", rdata_out, empty);
    end
    drain_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    drain_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wen_in = 1'b1; waddr_in = 5'(20 + i); wdata_in = 32'(100 + i);
      raddr_in = 5'(20 + i); mem_rdata = 32'(500 + i);
      #1;
      if (i > 0) begin
        checks++;
        if (mem_wen !== 1'b1 || mem_wdata !== 32'(99 + i) || count !== 3'd1) begin
          failures++;
          $display("FAIL b2b_step%0d got wen=%0b data=%0d count=%0d exp data=%0d count=1",
                   i, mem_wen, mem_wdata, count, 99 + i);
        end
      end
      tick();
    end
    wen_in = 1'b0;
    #1;
    checks++;
    if (mem_wdata !== 32'd109 || mem_waddr !== 5'd29) begin
      failures++;
      $display("FAIL b2b_last got addr=%0d data=%0d exp 29/109", mem_waddr, mem_wdata);
    end
    tick();
    drain_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    drain_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wen_in = 1'b1; waddr_in = 5'(i + 1); wdata_in = 32'(70 + i);
      tick();
    end
    wen_in = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (count !== 3'd0 || empty !== 1'b1 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_state got count=%0d empty=%0b ovf=%0b exp 0/1/0", count, empty, overflow);
    end
    drain_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (mem_wen !== 1'b0) begin
        failures++;
        $display("FAIL rstmid_no_write got=%0b exp=0", mem_wen);
      end
      tick();
    end
    drain_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wen_in = 1'b0; waddr_in = 5'd0; wdata_in = 32'd0;
    raddr_in = 5'd0; drain_en = 1'b0; mem_rdata = 32'd0;
    test_reset();
    test_single_store();
    test_fill_overflow();
    test_forward();
    test_back_to_back();
    test_reset_mid();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
